// File: rtl/fantasticfft_pkg.sv
// fantasticfft_pkg: shared FFT8 sizes, Q8.8 complex sample types and helpers.
//   FFT8_N / FFT8_LOG2N   : frame length and its log2
//   FIXED_INT / FIXED_FRAC: Q8.8 split of every sample component
//   fixed_t / cplx_t      : signed Q8.8 scalar and {re, im} complex pair
//   bank_state_e          : per-bank write-side state of the frame loader
//   bitrev3               : 3-bit index reversal used for FFT input ordering
package fantasticfft_pkg;
    localparam int FFT8_N     = 8;
    localparam int FFT8_LOG2N = 3;
    localparam int FIXED_INT  = 8;
    localparam int FIXED_FRAC = 8;
    typedef logic signed [FIXED_INT-1:-FIXED_FRAC] fixed_t;
    typedef struct packed {
        fixed_t re;
        fixed_t im;
    } cplx_t;
    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;
    function automatic logic [FFT8_LOG2N-1:0] bitrev3(input logic [FFT8_LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction
endpackage

// File: rtl/fft8_frame_bank.sv
// fft8_frame_bank: one 8-slot complex sample buffer of the ping-pong pair.
//   clk, rst_n : clock, asynchronous active-low reset (clears all slots)
//   we         : write enable
//   slot       : slot written when we=1
//   wdata      : complex sample to store
//   rdata      : all slots, slot j at [32j+31:32j] as {re, im}
module fft8_frame_bank
    import fantasticfft_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [FFT8_LOG2N-1:0]             slot,
    input  cplx_t                             wdata,
    output logic [FFT8_N*$bits(cplx_t)-1:0]   rdata
);
    cplx_t [FFT8_N-1:0] data_q, data_d;
    always_comb begin
        data_d = data_q;
        if (we) data_d[slot] = wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end
    assign rdata = data_q;
endmodule

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: gathers 8-sample frames into ping-pong banks for the FFT8 core.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : input sample handshake
//   s_re, s_im          : Q8.8 sample components
//   s_last              : marks the 8th sample of a frame
//   m_valid/m_ready     : frame handshake towards the FFT core
//   m_re, m_im          : 8 packed Q8.8 components, slot j at [16j+15:16j]
//   err_framing         : 1-cycle pulse when s_last disagrees with the sample index
//   drop_cnt            : saturating count of discarded short frames
module fft8_frame_loader
    import fantasticfft_pkg::*;
#(
    parameter bit BITREV    = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [15:0]           s_re,
    input  logic [15:0]           s_im,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [127:0]          m_re,
    output logic [127:0]          m_im,
    output logic                  err_framing,
    output logic [ERR_CNT_W-1:0]  drop_cnt
);
    localparam int CW = $bits(cplx_t);

    bank_state_e st_q [2];
    bank_state_e st_d [2];
    logic [FFT8_LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  err_q, err_d;
    logic [ERR_CNT_W-1:0]  drop_q, drop_d;
    logic [1:0]            full;
    logic                  accept, complete, discard, drain;
    logic [FFT8_N*CW-1:0]  rd_data [2];
    logic [FFT8_N*CW-1:0]  rd_sel;
    logic [FFT8_LOG2N-1:0] wr_slot;

    assign accept   = s_valid && s_ready;
    assign complete = accept && (wr_idx_q == 3'd7);
    // A short frame is only ever dropped; a late s_last on slot 7 still delivers.
    assign discard  = accept && s_last && (wr_idx_q != 3'd7);
    assign drain    = m_valid && m_ready;
    assign wr_slot  = BITREV ? bitrev3(wr_idx_q) : wr_idx_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]   <= BANK_EMPTY;
            st_q[1]   <= BANK_EMPTY;
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            st_q      <= st_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state logic. A bank being filled is never full, so a write and a
    // drain can never target the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
            if (accept && wr_bank_q == 1'(b))
                st_d[b] = complete ? BANK_FULL : discard ? BANK_EMPTY : BANK_FILLING;
            if (drain && rd_bank_q == 1'(b))
                st_d[b] = BANK_EMPTY;
        end
        wr_idx_d  = discard ? '0 : wr_idx_q + FFT8_LOG2N'(accept);
        wr_bank_d = wr_bank_q ^ complete;
        rd_bank_d = rd_bank_q ^ drain;
        err_d     = accept && (s_last != (wr_idx_q == 3'd7));
        drop_d    = (discard && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end

    // Outputs
    always_comb begin
        full[0]     = st_q[0] == BANK_FULL;
        full[1]     = st_q[1] == BANK_FULL;
        s_ready     = !full[wr_bank_q];
        m_valid     = full[rd_bank_q];
        err_framing = err_q;
        drop_cnt    = drop_q;
        rd_sel      = rd_data[rd_bank_q];
        m_re        = '0;
        m_im        = '0;
        for (int j = 0; j < FFT8_N; j++) begin
            m_re[16*j +: 16] = rd_sel[CW*j+16 +: 16];
            m_im[16*j +: 16] = rd_sel[CW*j +: 16];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft8_frame_bank u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (accept && wr_bank_q == 1'(g)),
            .slot  (wr_slot),
            .wdata ({s_re, s_im}),
            .rdata (rd_data[g])
        );
    end
endmodule
